// File: rtl/regfile_write_arbiter_if.sv
// Writeback request bundle for requesters A (ALU) and B (memory load):
// valid/ready handshake with destination register and value per requester.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_reg;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_reg;
    logic [DATA_W-1:0] b_data;

    modport master (
        output a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_reg, a_data, b_valid, b_reg, b_data,
        output a_ready, b_ready
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two writeback requesters using
// one-entry holding registers, age/round-robin arbitration and a registered output.
module regfile_write_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit DROP_R0  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    regfile_write_arbiter_if.slave req,
    output logic                  reg_write,
    output logic [ADDR_W-1:0]     write_reg,
    output logic [DATA_W-1:0]     write_data,
    output logic [NUM_REGS-1:0]   busy_mask
);
    typedef enum logic {PREFER_A = 1'b0, PREFER_B = 1'b1} rr_t;

    logic              full_a, full_b, a_older;
    logic [ADDR_W-1:0] reg_a, reg_b;
    logic [DATA_W-1:0] data_a, data_b;
    rr_t               rr;

    logic              grant_a, grant_b, grant_any;
    logic              acc_a, acc_b, a_older_next;
    logic [ADDR_W-1:0] granted_reg;
    logic [DATA_W-1:0] granted_data;

    // Grant depends only on registered state, never on the incoming valids.
    always_comb begin
        grant_a = full_a;
        grant_b = full_b;
        if (full_a && full_b) begin
            if (reg_a == reg_b) begin
                grant_a = a_older;
                grant_b = ~a_older;
            end else begin
                grant_a = (rr == PREFER_A);
                grant_b = (rr == PREFER_B);
            end
        end
        grant_any    = grant_a | grant_b;
        granted_reg  = grant_b ? reg_b  : reg_a;
        granted_data = grant_b ? data_b : data_a;
    end

    assign req.a_ready = ~rst & (~full_a | grant_a);
    assign req.b_ready = ~rst & (~full_b | grant_b);
    assign acc_a       = req.a_valid & req.a_ready;
    assign acc_b       = req.b_valid & req.b_ready;

    // Age tracks the entries that remain held after this edge.
    always_comb begin
        a_older_next = a_older;
        if (acc_a && acc_b)
            a_older_next = 1'b1;
        else if (acc_a)
            a_older_next = ~(full_b & ~grant_b);
        else if (acc_b)
            a_older_next = full_a & ~grant_a;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_a     <= 1'b0;
            full_b     <= 1'b0;
            reg_a      <= '0;
            reg_b      <= '0;
            data_a     <= '0;
            data_b     <= '0;
            a_older    <= 1'b0;
            rr         <= PREFER_A;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
        end else begin
            if (acc_a) begin
                full_a <= 1'b1;
                reg_a  <= req.a_reg;
                data_a <= req.a_data;
            end else if (grant_a) begin
                full_a <= 1'b0;
            end

            if (acc_b) begin
                full_b <= 1'b1;
                reg_b  <= req.b_reg;
                data_b <= req.b_data;
            end else if (grant_b) begin
                full_b <= 1'b0;
            end

            a_older <= a_older_next;

            if (grant_a)
                rr <= PREFER_B;
            else if (grant_b)
                rr <= PREFER_A;

            reg_write <= grant_any & ~(DROP_R0 && (granted_reg == '0));
            if (grant_any) begin
                write_reg  <= granted_reg;
                write_data <= granted_data;
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        if (full_a)
            busy_mask[reg_a] = 1'b1;
        if (full_b)
            busy_mask[reg_b] = 1'b1;
        if (reg_write)
            busy_mask[write_reg] = 1'b1;
        if (DROP_R0)
            busy_mask[0] = 1'b0;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: per-requester queues of accepted
// writes, a register-file model, and a monitor that checks every output pulse.
module tb_regfile_write_arbiter;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    logic              reg_write;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic [NUM_REGS-1:0] busy_mask;

    regfile_write_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .DROP_R0(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .req(bus.slave),
        .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .busy_mask(busy_mask)
    );

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        int unsigned seq;
        int unsigned cyc;
    } wr_t;

    wr_t         qa[$];
    wr_t         qb[$];
    int          pend_cnt[32];
    logic [31:0] ref_mem[32];
    logic [31:0] rf[32];
    logic [4:0]  wlog[$];
    int unsigned wcyc[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned seq_ctr = 0;
    int unsigned cyc = 0;
    bit          mon_en = 1'b0;
    bit          late_reported = 1'b0;

    bit          acc_a, acc_b;
    bit          pa = 1'b0, pb = 1'b0;
    logic [4:0]  ra = '0, rb = '0;
    logic [31:0] da = '0, db = '0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: every accepted write to a real register must eventually commit,
    // per-requester in order, never ahead of an older write to the same register.
    task automatic record(input bit is_b, input logic [4:0] r, input logic [31:0] d);
        wr_t e;
        if (r == 5'd0) return;
        e.r = r; e.d = d; e.seq = seq_ctr; e.cyc = cyc;
        seq_ctr++;
        pend_cnt[r]++;
        if (is_b) qb.push_back(e); else qa.push_back(e);
    endtask

    task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                         input bit bv, input logic [4:0] br, input logic [31:0] bd,
                         output bit oa, output bit ob);
        @(negedge clk); #1;
        bus.a_valid = av; bus.a_reg = ar; bus.a_data = ad;
        bus.b_valid = bv; bus.b_reg = br; bus.b_data = bd;
        #1;
        oa = av && (bus.a_ready === 1'b1);
        ob = bv && (bus.b_ready === 1'b1);
        if (oa) record(1'b0, ar, ad);
        if (ob) record(1'b1, br, bd);
    endtask

    task automatic idle(input int n);
        bit xa, xb;
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, xa, xb);
    endtask

    always @(negedge clk) begin : monitor
        logic [31:0] exp_busy;
        bit          hit_a, hit_b, use_a, bad;
        wr_t         e;
        if (mon_en) begin
            exp_busy = '0;
            for (int r = 0; r < 32; r++) if (pend_cnt[r] > 0) exp_busy[r] = 1'b1;
            chk("busy_mask", busy_mask, exp_busy);
            if (reg_write === 1'b1) begin
                wlog.push_back(write_reg);
                wcyc.push_back(cyc);
                hit_a = qa.size() > 0 && qa[0].r == write_reg && qa[0].d == write_data;
                hit_b = qb.size() > 0 && qb[0].r == write_reg && qb[0].d == write_data;
                use_a = (hit_a && hit_b) ? (qa[0].seq < qb[0].seq) : hit_a;
                checks++;
                if (!hit_a && !hit_b) begin
                    errors++;
                    $display("FAIL write_match: got r%0d=%h, required a queued head (A pending %0d, B pending %0d)",
                             write_reg, write_data, qa.size(), qb.size());
                end else begin
                    bad = 1'b0;
                    if (use_a) begin
                        e = qa.pop_front();
                        foreach (qb[i]) if (qb[i].r == e.r && qb[i].seq < e.seq) bad = 1'b1;
                    end else begin
                        e = qb.pop_front();
                        foreach (qa[i]) if (qa[i].r == e.r && qa[i].seq < e.seq) bad = 1'b1;
                    end
                    checks++;
                    if (bad) begin
                        errors++;
                        $display("FAIL write_order: got r%0d=%h committed, required older write to r%0d first",
                                 e.r, e.d, e.r);
                    end
                    ref_mem[e.r] = e.d;
                    pend_cnt[e.r]--;
                end
                rf[write_reg] = write_data;
            end
            if (!late_reported &&
                ((qa.size() > 0 && cyc - qa[0].cyc > 12) || (qb.size() > 0 && cyc - qb[0].cyc > 12))) begin
                late_reported = 1'b1;
                checks++;
                errors++;
                $display("FAIL commit_latency: got a write pending over 12 cycles, required commit within 12");
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: got no completion by 300us, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int na, nb;
        for (int r = 0; r < 32; r++) begin
            pend_cnt[r] = 0; ref_mem[r] = '0; rf[r] = '0;
        end

        // Reset with both requesters asserting valid.
        rst = 1'b1;
        bus.a_valid = 1'b1; bus.a_reg = 5'd1; bus.a_data = 32'h1;
        bus.b_valid = 1'b1; bus.b_reg = 5'd2; bus.b_data = 32'h2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_a_ready", 32'(bus.a_ready), 32'd0);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd0);
        chk("rst_reg_write", 32'(reg_write), 32'd0);
        chk("rst_write_reg", 32'(write_reg), 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        #1;
        chk("post_rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("post_rst_b_ready", 32'(bus.b_ready), 32'd1);
        mon_en = 1'b1;

        // Contention: alternating grants starting with A, one pulse per cycle.
        wlog.delete(); wcyc.delete();
        na = 0; nb = 0;
        for (int i = 0; i < 30 && (na < 4 || nb < 4); i++) begin
            drive(na < 4, 5'd2, 32'(10 + na), nb < 4, 5'd3, 32'(20 + nb), acc_a, acc_b);
            na += int'(acc_a); nb += int'(acc_b);
        end
        idle(4);
        chk("cont_count", 32'(wlog.size()), 32'd8);
        if (wlog.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("cont_order%0d", i), 32'(wlog[i]), (i % 2 == 0) ? 32'd2 : 32'd3);
            chk("cont_back_to_back", wcyc[7] - wcyc[0], 32'd7);
        end

        // Single write with exact pulse timing.
        drive(1'b1, 5'd1, 32'h0000FFFF, 1'b0, '0, '0, acc_a, acc_b);
        chk("single_accept", 32'(acc_a), 32'd1);
        idle(1);
        chk("single_wr_N", 32'(reg_write), 32'd0);
        chk("single_busy_N", 32'(busy_mask[1]), 32'd1);
        @(posedge clk); #1;
        chk("single_wr_N1", 32'(reg_write), 32'd1);
        chk("single_reg_N1", 32'(write_reg), 32'd1);
        chk("single_data_N1", write_data, 32'h0000FFFF);
        @(posedge clk); #1;
        chk("single_wr_N2", 32'(reg_write), 32'd0);
        chk("single_busy_N2", 32'(busy_mask[1]), 32'd0);
        chk("single_readback", rf[1], 32'h0000FFFF);

        // Same register: B first, then A one cycle later; A's value must remain.
        drive(1'b0, '0, '0, 1'b1, 5'd30, 32'hFFFF0000, acc_a, acc_b);
        drive(1'b1, 5'd30, 32'h1, 1'b0, '0, '0, acc_a, acc_b);
        idle(4);
        chk("same_reg_final", rf[30], 32'h1);

        // Writes to r0 are accepted and discarded.
        drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0, acc_a, acc_b);
        chk("r0_accept", 32'(acc_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("r0_no_write", 32'(reg_write), 32'd0);
            chk("r0_not_busy", 32'(busy_mask[0]), 32'd0);
        end

        // Randomized traffic concentrated on a few registers to force collisions.
        for (int i = 0; i < 400; i++) begin
            if (!pa && $urandom_range(0, 9) < 7) begin
                pa = 1'b1;
                ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
                da = $urandom;
            end
            if (!pb && $urandom_range(0, 9) < 7) begin
                pb = 1'b1;
                rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
                db = $urandom;
            end
            drive(pa, ra, da, pb, rb, db, acc_a, acc_b);
            if (acc_a) pa = 1'b0;
            if (acc_b) pb = 1'b0;
        end
        for (int i = 0; i < 60 && (pa || pb || qa.size() > 0 || qb.size() > 0); i++) begin
            drive(pa, ra, da, pb, rb, db, acc_a, acc_b);
            if (acc_a) pa = 1'b0;
            if (acc_b) pb = 1'b0;
        end
        chk("drain_empty", 32'(qa.size() + qb.size()), 32'd0);

        // Mid-operation reset: both held entries full and an output pulse live.
        drive(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB, acc_a, acc_b);
        chk("midrst_accept_both", 32'({acc_a, acc_b}), 32'd3);
        drive(1'b1, 5'd7, 32'hCCCC, 1'b1, 5'd8, 32'hDDDD, acc_a, acc_b);
        @(negedge clk); #1;
        rst = 1'b1; bus.a_valid = 1'b0; bus.b_valid = 1'b0;
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        for (int r = 0; r < 32; r++) pend_cnt[r] = 0;
        chk("midrst_busy", busy_mask, 32'd0);
        @(negedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("midrst_no_write", 32'(reg_write), 32'd0);
        end

        for (int r = 0; r < 32; r++)
            chk($sformatf("final_r%0d", r), rf[r], ref_mem[r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file between two writeback requesters: A (ALU result) and B (memory load result). Each requester gets a one-entry holding register with a valid/ready handshake. A round-robin arbiter, ordered by age when both entries target the same register, moves one entry per cycle into a registered output stage. That output stage drives the register file's `reg_write`/`write_reg`/`write_data` directly. A busy mask of in-flight destination registers goes to decode for hazard stalls.

## Interface
Parameters:
- `ADDR_W`, 5, register index width
- `DATA_W`, 32, data width
- `NUM_REGS`, 32, busy mask width (2^ADDR_W)
- `DROP_R0`, 1, when 1, writes targeting register 0 are accepted and discarded

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `a_valid`  in  1  requester A has a write
- `a_ready`  out  1  A transfer accepted at posedge when `a_valid & a_ready`
- `a_reg`  in  ADDR_W  A destination register
- `a_data`  in  DATA_W  A write value
- `b_valid`, `b_ready`, `b_reg`, `b_data`: same as A, for requester B
- `reg_write`  out  1  register file write enable (registered)
- `write_reg`  out  ADDR_W  register file write address (registered)
- `write_data`  out  DATA_W  register file write value (registered)
- `busy_mask`  out  NUM_REGS  bit r = 1 while a write to r is held or in the output stage

## Operation
State:
- `full_a`/`full_b` with captured reg/data per requester
- output stage: `reg_write`, `write_reg`, `write_data`
- `rr`: 0 = prefer A, 1 = prefer B
- `a_older`: set when A is captured while B is empty, or when both are captured in the same cycle

Grant, computed from registered state only (no dependence on `*_valid`):
- Neither full: no grant.
- One full: grant that one.
- Both full, same reg: grant the older (`a_older`).
- Both full, different reg: grant the `rr` side.

Handshake:
- `x_ready = ~rst & (~full_x | grant_x)`.
- A granted entry leaves its holding register at the same edge a new transfer can enter it, so each requester sustains 1 write/cycle when uncontended.
- When a transfer is accepted and the entry is not granted, `full_x` is set and reg/data are captured.
- Requesters must hold reg/data stable while `valid & ~ready`.

Output stage, at every posedge:
- `reg_write <= grant_any & ~(DROP_R0 & granted_reg == 0)`.
- `write_reg`/`write_data` load the granted entry on any grant.
- With no grant, they hold their value and `reg_write <= 0`.

Round-robin:
- After a grant to A, `rr <= 1`; after a grant to B, `rr <= 0`.
- `rr` is unchanged when there is no grant.

Busy mask:
- OR of the one-hot decode of `full_a`'s reg, `full_b`'s reg, and `write_reg` when `reg_write`.
- Register 0 is never marked busy when `DROP_R0 = 1`.
- Combinational from state.

Reset (`rst` high at posedge):
- `full_a = full_b = 0`, `reg_write = 0`, `write_reg = 0`, `write_data = 0`, `rr = 0`, `a_older = 0`.
- `busy_mask = 0`.
- Both readies are 0 while `rst` is high.
- Reset mid-operation discards held and output entries; no write is issued afterward.

## Timing
- Latency: a transfer accepted at posedge N is granted at the earliest at posedge N+1. `reg_write` is then high for exactly cycle N+1..N+2, and the register file commits at the negedge inside that cycle.
- A grant blocked by contention adds one cycle per losing round.
- At most one `reg_write` pulse per cycle; back-to-back pulses are allowed.
- `busy_mask` bit r rises the cycle after acceptance. It falls at the posedge ending the `reg_write` cycle, unless another entry still targets r.
- Same-register writes commit in acceptance order. For a same-cycle acceptance of both, A commits first, then B, so B's value wins.

## Test plan
- **Reset:** assert `rst` 2 cycles with `a_valid = b_valid = 1` -> `a_ready = b_ready = 0`, `reg_write = 0`, `write_reg = 0`, `write_data = 0`, `busy_mask = 0`. Release -> both readies 1.
- **Single write:** A writes r1 = 0x0000FFFF, accepted at edge N -> `reg_write = 1`, `write_reg = 1`, `write_data = 0x0000FFFF` during N+1 only. `busy_mask[1] = 1` during N..N+2. The register file reads back 0x0000FFFF.
- **Contention:** A (r2 = 10) and B (r3 = 20) held valid for 4 consecutive transfers each -> grants alternate A, B, A, B… starting with A after reset. One `reg_write` every cycle, none lost, order verified.
- **Same-register ordering:** B writes r30 = 0xFFFF0000 one cycle before A writes r30 = 0x1. Both are held -> B committed first, then A. Final r30 = 0x1. `busy_mask[30]` stays high across both.
- **r0 drop:** A writes r0 = 0x55 -> accepted (`a_ready = 1`), `reg_write` stays 0, `busy_mask[0]` stays 0.
- **Mid-operation reset:** both entries full and an output pulse pending, assert `rst` for 1 cycle -> no `reg_write` afterward, `busy_mask = 0`, the register file is unchanged for those registers.
